// File: rtl/boot_loader.sv
// Boot loader: receives a framed byte stream and writes it into instruction memory.
//   Frame: SYNC_BYTE, count_lo, count_hi, count x (word_lo, word_hi), checksum.
//   The checksum is the modulo-256 sum of every byte after SYNC_BYTE except itself.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   in_data/in_valid    - byte stream input; in_ready accepts (low only once loaded)
//   prog_addr/data/we   - instruction memory write port, one-cycle strobe per word
//   cpu_reset           - holds the downstream CPU in reset until the image is loaded
//   done / error        - image loaded and verified / last frame rejected
module boot_loader #(
  parameter int unsigned I_ADDR_WIDTH = 10,
  parameter int unsigned INSTR_WIDTH  = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [I_ADDR_WIDTH-1:0] prog_addr,
  output logic [INSTR_WIDTH-1:0]  prog_data,
  output logic                    prog_we,
  output logic                    cpu_reset,
  output logic                    done,
  output logic                    error
);

  // Word counts go up to 2**I_ADDR_WIDTH inclusive, so compare in 17 bits.
  localparam logic [16:0] MaxWords = 17'(2 ** I_ADDR_WIDTH);

  typedef enum logic [2:0] {
    StIdle, StCntLo, StCntHi, StDataLo, StDataHi, StCheck, StDone, StErr
  } state_e;

  state_e                  state_q, state_d;
  logic [15:0]             count_q, count_d;
  logic [7:0]              lo_q, lo_d;
  logic [7:0]              csum_q, csum_d;
  logic [16:0]             idx_q, idx_d;
  logic [I_ADDR_WIDTH-1:0] prog_addr_q, prog_addr_d;
  logic [INSTR_WIDTH-1:0]  prog_data_q, prog_data_d;
  logic                    prog_we_q, prog_we_d;
  logic                    in_ready_q, in_ready_d;
  logic                    cpu_reset_q, cpu_reset_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    accept;
  logic [16:0]             cnt_full;

  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    lo_d        = lo_q;
    csum_d      = csum_q;
    idx_d       = idx_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    prog_we_d   = 1'b0;
    cnt_full    = {1'b0, in_data, count_q[7:0]};

    if (accept) begin
      unique case (state_q)
        StIdle, StErr: begin
          if (in_data == SYNC_BYTE) begin
            state_d = StCntLo;
            csum_d  = 8'd0;
            idx_d   = 17'd0;
          end
        end
        StCntLo: begin
          count_d[7:0] = in_data;
          csum_d       = csum_q + in_data;
          state_d      = StCntHi;
        end
        StCntHi: begin
          count_d[15:8] = in_data;
          csum_d        = csum_q + in_data;
          if (cnt_full > MaxWords)    state_d = StErr;
          else if (cnt_full == 17'd0) state_d = StCheck;
          else                        state_d = StDataLo;
        end
        StDataLo: begin
          lo_d    = in_data;
          csum_d  = csum_q + in_data;
          state_d = StDataHi;
        end
        StDataHi: begin
          csum_d      = csum_q + in_data;
          prog_we_d   = 1'b1;
          prog_addr_d = idx_q[I_ADDR_WIDTH-1:0];
          prog_data_d = INSTR_WIDTH'({in_data, lo_q});
          idx_d       = idx_q + 17'd1;
          state_d     = (idx_q + 17'd1 == {1'b0, count_q}) ? StCheck : StDataLo;
        end
        StCheck: begin
          state_d = (in_data == csum_q) ? StDone : StErr;
        end
        default: ; // StDone is left only by reset
      endcase
    end

    // Status outputs are registered copies of the next state's decode.
    in_ready_d  = (state_d != StDone);
    cpu_reset_d = (state_d != StDone);
    done_d      = (state_d == StDone);
    error_d     = (state_d == StErr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= 16'd0;
      lo_q        <= 8'd0;
      csum_q      <= 8'd0;
      idx_q       <= 17'd0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_we_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      lo_q        <= lo_d;
      csum_q      <= csum_d;
      idx_q       <= idx_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      prog_we_q   <= prog_we_d;
      in_ready_q  <= in_ready_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign prog_addr = prog_addr_q;
  assign prog_data = prog_data_q;
  assign prog_we   = prog_we_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed frames plus randomized word data and
// randomized in_valid gaps, checked against frames and expected writes built here.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  prog_addr;
  logic [15:0] prog_data;
  logic        prog_we;
  logic        cpu_reset;
  logic        done;
  logic        error;

  boot_loader #(
    .I_ADDR_WIDTH(10),
    .INSTR_WIDTH (16),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .prog_we  (prog_we),
    .cpu_reset(cpu_reset),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] exp_wq[$];
  logic [31:0] got_wq[$];
  logic [15:0] wdat[1024];

  // Capture every write strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (prog_we === 1'b1) got_wq.push_back({6'd0, prog_addr, prog_data});
  end

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, ".in_ready"}, in_ready, 1'b1);
    check_bit({tag, ".prog_we"}, prog_we, 1'b0);
    check_word({tag, ".prog_addr"}, {22'd0, prog_addr}, 32'd0);
    check_word({tag, ".prog_data"}, {16'd0, prog_data}, 32'd0);
    check_bit({tag, ".cpu_reset"}, cpu_reset, 1'b1);
    check_bit({tag, ".done"}, done, 1'b0);
    check_bit({tag, ".error"}, error, 1'b0);
  endtask

  // Asserted mid-cycle so the outputs must react without a clock edge.
  task automatic do_reset(input bit check_now, input string tag);
    #3 reset = 1'b1;
    in_valid = 1'b0;
    #1;
    if (check_now) check_reset_outputs(tag);
    @(posedge clk);
    #1 reset = 1'b0;
    got_wq.delete();
    exp_wq.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int k;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk);
        #1;
      end
    end
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      k++;
    end
    if (in_ready !== 1'b1) check_bit("ready_timeout", in_ready, 1'b1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_all(input bit gaps);
    foreach (tx_q[i]) send_byte(tx_q[i], gaps);
    @(posedge clk);
    #1;
  endtask

  // Frame of cnt words from wdat, with the expected writes queued alongside.
  task automatic build_frame(input int cnt, input bit corrupt);
    int sum;
    tx_q.delete();
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'(cnt % 256));
    tx_q.push_back(8'(cnt / 256));
    sum = (cnt % 256) + (cnt / 256);
    for (int i = 0; i < cnt; i++) begin
      tx_q.push_back(wdat[i][7:0]);
      tx_q.push_back(wdat[i][15:8]);
      sum += wdat[i][7:0] + wdat[i][15:8];
      exp_wq.push_back({6'd0, 10'(i), wdat[i]});
    end
    tx_q.push_back(8'(sum % 256) ^ (corrupt ? 8'h5A : 8'h00));
  endtask

  task automatic compare_writes(input string tag);
    check_word({tag, ".nwrites"}, 32'(got_wq.size()), 32'(exp_wq.size()));
    for (int i = 0; i < exp_wq.size() && i < got_wq.size(); i++)
      check_word($sformatf("%s.write%0d", tag, i), got_wq[i], exp_wq[i]);
    got_wq.delete();
    exp_wq.delete();
  endtask

  task automatic check_status(input string tag, input logic d, input logic e);
    check_bit({tag, ".done"}, done, d);
    check_bit({tag, ".error"}, error, e);
    check_bit({tag, ".cpu_reset"}, cpu_reset, ~d);
    check_bit({tag, ".in_ready"}, in_ready, ~d);
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    do_reset(1'b1, "por");

    // Two-word frame; sum of 02 00 34 12 CD AB is C0.
    wdat[0] = 16'h1234;
    wdat[1] = 16'hABCD;
    build_frame(2, 1'b0);
    check_word("two.csum", {24'd0, tx_q[7]}, 32'hC0);
    send_all(1'b0);
    compare_writes("two");
    check_status("two", 1'b1, 1'b0);
    // DONE ignores further traffic.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    check_status("two_hold", 1'b1, 1'b0);
    check_bit("two_hold.we", prog_we, 1'b0);

    // Leading junk then an empty frame.
    do_reset(1'b1, "rst1");
    tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_all(1'b0);
    compare_writes("empty");
    check_status("empty", 1'b1, 1'b0);

    // Bad checksum keeps the written word, then a good empty frame recovers.
    do_reset(1'b0, "");
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h00};
    exp_wq.push_back({6'd0, 10'd0, 16'h2211});
    send_all(1'b0);
    compare_writes("badsum");
    check_status("badsum", 1'b0, 1'b1);
    tx_q = '{8'h37, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_all(1'b0);
    compare_writes("recover");
    check_status("recover", 1'b1, 1'b0);

    // Oversize count 0x0401 rejected right after count_hi.
    do_reset(1'b0, "");
    tx_q = '{8'hA5, 8'h01, 8'h04};
    send_all(1'b0);
    check_status("oversize", 1'b0, 1'b1);
    tx_q = '{8'h12, 8'h34, 8'h56};
    send_all(1'b1);
    compare_writes("oversize");
    check_status("oversize_junk", 1'b0, 1'b1);

    // Reset after word 5's low byte: words 0..4 written, word 5 never.
    do_reset(1'b0, "");
    for (int i = 0; i < 8; i++) wdat[i] = 16'($urandom);
    build_frame(8, 1'b0);
    for (int i = 0; i < 3 + 11; i++) send_byte(tx_q[i], 1'b1);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    repeat (3) void'(exp_wq.pop_back());
    compare_writes("midrst");
    for (int i = 0; i < 8; i++) wdat[i] = 16'($urandom);
    build_frame(8, 1'b0);
    send_all(1'b1);
    compare_writes("after_rst");
    check_status("after_rst", 1'b1, 1'b0);

    // Random small frames, checksum randomly corrupted.
    for (int r = 0; r < 4; r++) begin
      int  cnt;
      bit  bad;
      do_reset(1'b0, "");
      cnt = $urandom_range(1, 6);
      bad = 1'($urandom_range(0, 1));
      for (int i = 0; i < cnt; i++) wdat[i] = 16'($urandom);
      build_frame(cnt, bad);
      send_all(1'b1);
      compare_writes($sformatf("rnd%0d", r));
      check_status($sformatf("rnd%0d", r), ~bad, bad);
    end

    // Full 1024-word image with random in_valid gaps.
    do_reset(1'b0, "");
    for (int i = 0; i < 1024; i++) wdat[i] = 16'($urandom);
    build_frame(1024, 1'b0);
    send_all(1'b1);
    if (got_wq.size() > 0) check_word("full.last_addr", {16'd0, got_wq[$][31:16]}, 32'd1023);
    else check_word("full.last_addr", 32'hFFFF_FFFF, 32'd1023);
    compare_writes("full");
    check_status("full", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
